// File: rtl/updown_timer_pkg.sv
// Shared types and constant helpers for the up/down timer.
package updown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_e;

    // Bits needed to index 'value' distinct states; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_timer_tick.sv
// Prescaler: one-cycle tick every DIV enabled cycles, restart on clr.
// Tick is combinational from the counter register; never stalls.
module tick_gen
    import updown_timer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic Clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (clog2(DIV) > 0) ? clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/updown_timer.sv
// Up/down counter with run control, load, wrap-or-saturate terminal and timed buzzer.
// All outputs registered, one-cycle response to inputs; no backpressure.
module updown_timer
    import updown_timer_pkg::*;
#(
    parameter int WIDTH      = 7,
    parameter int MAX        = 99,
    parameter int DIV        = 1,
    parameter int BUZ_CYCLES = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             up_down,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] Count,
    output logic             running,
    output logic             tc,
    output logic             buz
);

    localparam int TW = clog2(BUZ_CYCLES + 1);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [TW-1:0]    BUZ_V = TW'(BUZ_CYCLES);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [TW-1:0]    btmr_q, btmr_d;
    logic             tc_q, tc_d;
    logic             running_q, running_d;
    logic             buz_q, buz_d;
    logic             tick;
    logic             at_term;

    // Prescaler is held at zero outside RUN, so entering RUN always starts a full period.
    tick_gen #(.DIV(DIV)) u_tick (
        .Clk   (Clk),
        .reset (reset),
        .en    (state_q == RUN),
        .clr   (load || (state_q != RUN)),
        .tick  (tick)
    );

    assign at_term = up_down ? (count_q == MAX_V) : (count_q == '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        btmr_d  = (btmr_q != '0) ? btmr_q - 1'b1 : '0;

        if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
            if (state_q == ALARM) begin
                state_d = IDLE;
            end
        end else if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (at_term) begin
                            tc_d = 1'b1;
                            if (wrap_en) begin
                                count_d = up_down ? '0 : MAX_V;
                                btmr_d  = BUZ_V;
                            end else begin
                                state_d = ALARM;
                            end
                        end else begin
                            count_d = up_down ? count_q + 1'b1 : count_q - 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        running_d = (state_d == RUN);
        buz_d     = (state_d == ALARM) || (btmr_d != '0);
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            btmr_q    <= '0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            buz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            btmr_q    <= btmr_d;
            tc_q      <= tc_d;
            running_q <= running_d;
            buz_q     <= buz_d;
        end
    end

    assign Count   = count_q;
    assign running = running_q;
    assign tc      = tc_q;
    assign buz     = buz_q;

endmodule

// File: tb/tb_updown_timer.sv
// Directed bench for updown_timer: DIV=1 and DIV=4 instances share stimulus and are
// checked every cycle against a behavioural model, plus hand-computed spot values.
module tb_updown_timer;

    localparam int MAXV = 99;
    localparam int BUZV = 8;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       up_down = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_val = '0;
    logic       wrap_en = 1'b1;

    logic [6:0] cnt1, cnt4;
    logic       run1, run4, tc1, tc4, buz1, buz4;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    updown_timer #(.WIDTH(7), .MAX(99), .DIV(1), .BUZ_CYCLES(8)) u_dut1 (
        .Clk(Clk), .reset(reset), .up_down(up_down), .start(start), .stop(stop),
        .load(load), .load_val(load_val), .wrap_en(wrap_en),
        .Count(cnt1), .running(run1), .tc(tc1), .buz(buz1)
    );

    updown_timer #(.WIDTH(7), .MAX(99), .DIV(4), .BUZ_CYCLES(8)) u_dut4 (
        .Clk(Clk), .reset(reset), .up_down(up_down), .start(start), .stop(stop),
        .load(load), .load_val(load_val), .wrap_en(wrap_en),
        .Count(cnt4), .running(run4), .tc(tc4), .buz(buz4)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 run, 2 alarm; phase = RUN cycles since last step.
    int m_mode[2], m_cnt[2], m_phase[2], m_buz[2], m_tc[2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic model_edge(input int i);
        m_tc[i] = 0;
        if (m_buz[i] > 0) m_buz[i]--;
        if (load) begin
            m_cnt[i]   = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
            m_phase[i] = 0;
            if (m_mode[i] == 2) m_mode[i] = 0;
        end else if (stop) begin
            m_mode[i] = 0;
        end else if (m_mode[i] == 0) begin
            if (start) begin
                m_mode[i]  = 1;
                m_phase[i] = 0;
            end
        end else if (m_mode[i] == 1) begin
            m_phase[i]++;
            if (m_phase[i] == div_of(i)) begin
                m_phase[i] = 0;
                if ((up_down && m_cnt[i] == MAXV) || (!up_down && m_cnt[i] == 0)) begin
                    m_tc[i] = 1;
                    if (wrap_en) begin
                        m_cnt[i] = up_down ? 0 : MAXV;
                        m_buz[i] = BUZV;
                    end else begin
                        m_mode[i] = 2;
                    end
                end else begin
                    m_cnt[i] = up_down ? m_cnt[i] + 1 : m_cnt[i] - 1;
                end
            end
        end
    endtask

    always @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_cnt[i] = 0; m_phase[i] = 0; m_buz[i] = 0; m_tc[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_edge(i);
        end
    end

    always @(negedge Clk) begin
        if (chk_en && reset) begin
            chk("cmp_count_div1",   int'(cnt1), m_cnt[0]);
            chk("cmp_running_div1", int'(run1), int'(m_mode[0] == 1));
            chk("cmp_tc_div1",      int'(tc1),  m_tc[0]);
            chk("cmp_buz_div1",     int'(buz1), int'(m_mode[0] == 2 || m_buz[0] > 0));
            chk("cmp_count_div4",   int'(cnt4), m_cnt[1]);
            chk("cmp_running_div4", int'(run4), int'(m_mode[1] == 1));
            chk("cmp_tc_div4",      int'(tc4),  m_tc[1]);
            chk("cmp_buz_div4",     int'(buz4), int'(m_mode[1] == 2 || m_buz[1] > 0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        int hi;
        cyc(2);
        chk("rst_count", int'(cnt1), 0);
        chk("rst_running", int'(run1), 0);
        chk("rst_tc", int'(tc1), 0);
        chk("rst_buz", int'(buz1), 0);
        reset = 1'b1;
        chk_en = 1'b1;

        // Up-count with wrap: 0..99 then back to 0 with tc and an 8-cycle buzz.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("t1_start_count", int'(cnt1), 0);
        chk("t1_start_running", int'(run1), 1);
        cyc(99);
        chk("t1_at_max", int'(cnt1), 99);
        chk("t1_tc_before_wrap", int'(tc1), 0);
        cyc(1);
        chk("t1_wrap_count", int'(cnt1), 0);
        chk("t1_wrap_tc", int'(tc1), 1);
        hi = int'(buz1);
        repeat (11) begin
            cyc(1);
            hi += int'(buz1);
        end
        chk("t1_buz_len", hi, 8);

        // Down-count from 0 wraps to MAX on the first tick.
        stop = 1'b1; cyc(1); stop = 1'b0;
        load_val = 7'd0; load = 1'b1; cyc(1); load = 1'b0;
        up_down = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t2_start_count", int'(cnt1), 0);
        cyc(1);
        chk("t2_wrap_count", int'(cnt1), 99);
        chk("t2_wrap_tc", int'(tc1), 1);
        chk("t2_wrap_buz", int'(buz1), 1);
        cyc(2);
        chk("t2_div4_pre", int'(cnt4), 0);
        cyc(1);
        chk("t2_div4_wrap", int'(cnt4), 99);
        chk("t2_div4_tc", int'(tc4), 1);
        stop = 1'b1; cyc(1); stop = 1'b0;

        // Saturate: 97, 98, 99, then hold in ALARM; start is ignored there.
        wrap_en = 1'b0; up_down = 1'b1;
        load_val = 7'd97; load = 1'b1; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1);
        chk("t3_count_97", int'(cnt1), 97);
        cyc(1);
        chk("t3_count_98", int'(cnt1), 98);
        cyc(1);
        chk("t3_count_99", int'(cnt1), 99);
        cyc(1);
        chk("t3_sat_count", int'(cnt1), 99);
        chk("t3_sat_tc", int'(tc1), 1);
        chk("t3_alarm_running", int'(run1), 0);
        chk("t3_alarm_buz", int'(buz1), 1);
        cyc(2);
        chk("t3_hold_count", int'(cnt1), 99);
        chk("t3_hold_buz", int'(buz1), 1);
        chk("t3_start_ignored", int'(run1), 0);
        start = 1'b0; stop = 1'b1; cyc(1); stop = 1'b0;
        chk("t3_stop_buz", int'(buz1), 0);

        // Prescaler DIV=4 with a mid-run load.
        wrap_en = 1'b1;
        load_val = 7'd10; load = 1'b1; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t4_k_count", int'(cnt4), 10);
        cyc(3);
        chk("t4_k3_count", int'(cnt4), 10);
        cyc(1);
        chk("t4_k4_count", int'(cnt4), 11);
        cyc(1);
        load_val = 7'd50; load = 1'b1; cyc(1); load = 1'b0;
        chk("t4_load_count", int'(cnt4), 50);
        cyc(3);
        chk("t4_k9_count", int'(cnt4), 50);
        cyc(1);
        chk("t4_k10_count", int'(cnt4), 51);
        chk("t4_div1_count", int'(cnt1), 54);

        // start+stop together, clamped load, load out of ALARM.
        stop = 1'b1; cyc(1); stop = 1'b0;
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        chk("t5_both_running", int'(run1), 0);
        load_val = 7'd120; load = 1'b1; cyc(1); load = 1'b0;
        chk("t5_clamp_count", int'(cnt1), 99);
        wrap_en = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(1);
        chk("t5_alarm_buz", int'(buz1), 1);
        load_val = 7'd5; load = 1'b1; cyc(1); load = 1'b0;
        chk("t5_alarm_load_count", int'(cnt1), 5);
        chk("t5_alarm_load_buz", int'(buz1), 0);
        chk("t5_alarm_load_running", int'(run1), 0);
        stop = 1'b1; cyc(1); stop = 1'b0;

        // Asynchronous reset while running with the buzzer active.
        wrap_en = 1'b1; up_down = 1'b0;
        load_val = 7'd0; load = 1'b1; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(2);
        chk("t6_pre_buz", int'(buz1), 1);
        chk("t6_pre_running", int'(run1), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_count", int'(cnt1), 0);
        chk("t6_async_buz", int'(buz1), 0);
        chk("t6_async_running", int'(run1), 0);
        chk("t6_async_count_div4", int'(cnt4), 0);
        @(negedge Clk);
        reset = 1'b1;
        up_down = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/updown_timer.md
# updown_timer

Parametrised up/down counter with run control, load, wrap-or-saturate terminal handling and a timed buzzer output. It replaces the fixed 7-bit up/down counter used on the Spartan-6 edge board and drives seven-segment count displays and the on-board buzzer. A clock-enable prescaler lets one block count at board-clock rate or at a slow human-visible rate.

## Interface
- WIDTH, 7: width of Count and load_val.
- MAX, 99: terminal value for up count; legal range 1..2^WIDTH-1.
- DIV, 1: prescaler ratio; one count step per DIV Clk cycles in RUN; DIV >= 1.
- BUZ_CYCLES, 8: buz pulse length in Clk cycles after a wrap event; >= 1.

- Clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- up_down  in  1  1 = count up, 0 = count down; sampled on each tick.
- start  in  1  level; enter RUN from IDLE.
- stop  in  1  level; leave RUN or ALARM to IDLE.
- load  in  1  level; Count <= min(load_val, MAX).
- load_val  in  WIDTH  load value.
- wrap_en  in  1  1 = wrap at terminal, 0 = saturate and alarm.
- Count  out  WIDTH  current count, registered.
- running  out  1  high while state = RUN.
- tc  out  1  one-cycle pulse on each terminal event.
- buz  out  1  buzzer drive.

## Operation
- States: IDLE, RUN, ALARM. Reset -> IDLE.
- Per-edge priority: reset > load > stop > start > count step.
- IDLE: Count holds; start=1 and stop=0 -> RUN.
- RUN: stop=1 -> IDLE (Count holds). Otherwise on each prescaler tick step Count by +1 (up_down=1) or -1 (up_down=0).
- Terminal event: tick in RUN while Count == terminal (MAX when up, 0 when down).
  - wrap_en=1: Count -> 0 (up) or MAX (down); tc=1 one cycle; buz timer loaded with BUZ_CYCLES; stay RUN.
  - wrap_en=0: Count holds; tc=1 one cycle; -> ALARM.
- ALARM: buz=1 continuously; Count holds; start ignored; stop=1 -> IDLE; load=1 -> IDLE with loaded value.
- Load: allowed in any state. Count <= load_val, or MAX if load_val > MAX. Prescaler cleared. RUN stays RUN. IDLE stays IDLE. ALARM -> IDLE.
- start and stop high together: stop wins.
- buz = (state == ALARM) OR (buz timer != 0). A wrap event during an active timer reloads it to BUZ_CYCLES.
- Count never exceeds MAX. Arithmetic is WIDTH-bit with explicit terminal compare and no natural binary overflow.

## Timing
- Reset values: Count=0, running=0, tc=0, buz=0, state IDLE, prescaler 0, buz timer 0. Applied asynchronously; release is synchronous to Clk.
- Prescaler counts only in RUN. It is cleared on entry to RUN and on load. Tick fires when it reaches DIV-1; with DIV=1, every RUN cycle is a tick.
- start sampled at edge k -> running=1 after edge k; first Count change after edge k+DIV.
- stop sampled at edge k -> running=0 after edge k; no step at edge k even if a tick coincides.
- load at edge k -> Count = new value after edge k; next step after edge k+DIV if in RUN.
- Wrap event at edge k -> tc high for cycle k..k+1; buz high for exactly BUZ_CYCLES cycles from edge k.
- up_down change takes effect on the next tick; no extra latency.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package updown_timer_pkg: state enum (IDLE, RUN, ALARM) and a clog2 function for the prescaler and buz timer widths.
- One sub-module, tick_gen (parameter DIV; inputs Clk, reset, en, clr; output tick), holds the prescaler. The FSM, count datapath and buz timer stay in updown_timer.

## Test plan
- WIDTH=7, MAX=99, DIV=1, wrap_en=1, up_down=1: start from reset, run 105 cycles -> Count 0..99, wraps to 0; tc pulses once at the 99->0 step; buz high 8 cycles.
- Same setup, up_down=0 from Count=0 -> Count becomes 99 at the first tick; tc=1; buz 8 cycles.
- wrap_en=0, load 97, start, up -> Count 98, 99, then holds at 99; state ALARM; buz stays high; stop -> IDLE, buz=0 next cycle.
- DIV=4: start at edge k -> Count steps at k+4, k+8; load 50 mid-run at k+6 -> Count 50, next step at k+10 to 51.
- start and stop high together in IDLE -> stays IDLE. load_val=120 -> Count=99.
- Assert reset low mid-RUN with buz active -> Count=0, buz=0, running=0 immediately, without waiting for a Clk edge.
